// File: rtl/branch_resolve_bht.sv
// rtl/branch_resolve_bht.sv - branch resolution unit with bimodal history table and statistics
module branch_resolve_bht #(
    parameter int DATA_W     = 32,
    parameter int PC_W       = 32,
    parameter int BHT_DEPTH  = 64,
    parameter int CNT_W      = 2,
    parameter int INIT_CNT   = 1,
    parameter int SIGNED_CMP = 1,
    parameter int STAT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   pred_pc,
    output logic              pred_taken,
    input  logic              stall,
    input  logic              res_valid,
    input  logic [PC_W-1:0]   res_pc,
    input  logic [2:0]        res_cond,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [PC_W-1:0]   res_target,
    input  logic              res_pred_taken,
    output logic              flush,
    output logic [PC_W-1:0]   redirect_pc,
    output logic              actual_taken,
    output logic [1:0]        cmp_result,
    output logic [STAT_W-1:0] branch_cnt,
    output logic [STAT_W-1:0] mispredict_cnt
);

    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_RST  = CNT_W'(INIT_CNT);
    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

    localparam logic [2:0] C_BEQ  = 3'd0;
    localparam logic [2:0] C_BNE  = 3'd1;
    localparam logic [2:0] C_BLTZ = 3'd2;
    localparam logic [2:0] C_BGTZ = 3'd3;
    localparam logic [2:0] C_BLEZ = 3'd4;
    localparam logic [2:0] C_BGEZ = 3'd5;

    localparam logic [1:0] R_NONE = 2'b00;
    localparam logic [1:0] R_EQ   = 2'b01;
    localparam logic [1:0] R_LT   = 2'b10;
    localparam logic [1:0] R_GT   = 2'b11;

    logic [CNT_W-1:0]  bht_q [BHT_DEPTH];
    logic [IDX_W-1:0]  pred_idx;
    logic [IDX_W-1:0]  res_idx;
    logic [CNT_W-1:0]  res_cnt;
    logic [DATA_W-1:0] cmp_b;
    logic              is_eq;
    logic              lt_signed;
    logic              lt_unsigned;
    logic              is_lt;
    logic [1:0]        result;
    logic              taken;
    logic              acc;
    logic              mis;
    logic [PC_W-1:0]   redirect_next;
    logic              unused_pred_bits;

    assign pred_idx = pred_pc[IDX_W+1:2];
    assign res_idx  = res_pc[IDX_W+1:2];
    assign res_cnt  = bht_q[res_idx];

    // Plain array read: an update landing this cycle is not forwarded.
    assign pred_taken = bht_q[pred_idx][CNT_W-1];

    assign unused_pred_bits = ^{pred_pc[PC_W-1:IDX_W+2], pred_pc[1:0]};

    always_comb begin
        cmp_b = '0;
        if (res_cond == C_BEQ || res_cond == C_BNE) begin
            cmp_b = rt_data;
        end
    end

    assign is_eq       = (rs_data == cmp_b);
    assign lt_signed   = ($signed(rs_data) < $signed(cmp_b));
    assign lt_unsigned = (rs_data < cmp_b);
    assign is_lt       = (SIGNED_CMP != 0) ? lt_signed : lt_unsigned;

    always_comb begin
        result = R_GT;
        if (is_eq) begin
            result = R_EQ;
        end else if (is_lt) begin
            result = R_LT;
        end
    end

    always_comb begin
        taken = 1'b0;
        case (res_cond)
            C_BEQ:   taken = (result == R_EQ);
            C_BNE:   taken = (result != R_EQ);
            C_BLTZ:  taken = (result == R_LT);
            C_BGTZ:  taken = (result == R_GT);
            C_BLEZ:  taken = (result != R_GT);
            C_BGEZ:  taken = (result != R_LT);
            default: taken = 1'b0;
        endcase
    end

    // A resolve arriving while flush is high sits on the wrong path and is dropped.
    assign acc           = res_valid & ~stall & ~flush;
    assign mis           = (taken != res_pred_taken);
    assign redirect_next = taken ? res_target : (res_pc + PC_W'(4));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= CNT_RST;
            end
        end else if (acc) begin
            if (taken && res_cnt != CNT_MAX) begin
                bht_q[res_idx] <= res_cnt + CNT_W'(1);
            end else if (!taken && res_cnt != CNT_ZERO) begin
                bht_q[res_idx] <= res_cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush        <= 1'b0;
            actual_taken <= 1'b0;
            cmp_result   <= R_NONE;
            redirect_pc  <= '0;
        end else if (acc) begin
            flush        <= mis;
            actual_taken <= taken;
            cmp_result   <= result;
            redirect_pc  <= redirect_next;
        end else begin
            flush        <= 1'b0;
            actual_taken <= 1'b0;
            cmp_result   <= R_NONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else if (acc) begin
            if (branch_cnt != STAT_MAX) begin
                branch_cnt <= branch_cnt + STAT_W'(1);
            end
            if (mis && mispredict_cnt != STAT_MAX) begin
                mispredict_cnt <= mispredict_cnt + STAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_bht.sv
// tb/tb_branch_resolve_bht.sv - scoreboard bench for branch_resolve_bht
module tb_branch_resolve_bht;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pred_pc;
    logic        stall;
    logic        res_valid;
    logic [31:0] res_pc;
    logic [2:0]  res_cond;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] res_target;
    logic        res_pred_taken;

    logic        pred_taken,   u_pred_taken;
    logic        flush,        u_flush;
    logic [31:0] redirect_pc,  u_redirect_pc;
    logic        actual_taken, u_actual_taken;
    logic [1:0]  cmp_result,   u_cmp_result;
    logic [31:0] branch_cnt,   u_branch_cnt;
    logic [31:0] mispredict_cnt, u_mispredict_cnt;

    always #5 clk = ~clk;

    branch_resolve_bht dut (
        .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .stall(stall), .res_valid(res_valid), .res_pc(res_pc), .res_cond(res_cond),
        .rs_data(rs_data), .rt_data(rt_data), .res_target(res_target),
        .res_pred_taken(res_pred_taken), .flush(flush), .redirect_pc(redirect_pc),
        .actual_taken(actual_taken), .cmp_result(cmp_result),
        .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
    );

    branch_resolve_bht #(.SIGNED_CMP(0)) dut_u (
        .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(u_pred_taken),
        .stall(stall), .res_valid(res_valid), .res_pc(res_pc), .res_cond(res_cond),
        .rs_data(rs_data), .rt_data(rt_data), .res_target(res_target),
        .res_pred_taken(res_pred_taken), .flush(u_flush), .redirect_pc(u_redirect_pc),
        .actual_taken(u_actual_taken), .cmp_result(u_cmp_result),
        .branch_cnt(u_branch_cnt), .mispredict_cnt(u_mispredict_cnt)
    );

    typedef struct {
        logic        flush;
        logic        taken;
        logic [1:0]  cmp;
        logic [31:0] redir;
        logic [31:0] bcnt;
        logic [31:0] mcnt;
        logic        pred;
        logic        chk_u;
        logic        u_flush;
        logic        u_taken;
        logic [1:0]  u_cmp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic f, input logic t, input logic [1:0] c,
                                input logic [31:0] r, input logic [31:0] b,
                                input logic [31:0] m, input logic p);
        exp_t e;
        e.flush = f; e.taken = t; e.cmp = c; e.redir = r;
        e.bcnt = b; e.mcnt = m; e.pred = p;
        e.chk_u = 1'b0; e.u_flush = 1'b0; e.u_taken = 1'b0; e.u_cmp = 2'b00;
        return e;
    endfunction

    // Monitor: one expected entry per clock edge, compared just after the edge.
    exp_t mon_e;
    always @(posedge clk) begin
        #1;
        if (!rst && sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("flush",          {31'd0, flush},        {31'd0, mon_e.flush});
            check("actual_taken",   {31'd0, actual_taken}, {31'd0, mon_e.taken});
            check("cmp_result",     {30'd0, cmp_result},   {30'd0, mon_e.cmp});
            check("redirect_pc",    redirect_pc,           mon_e.redir);
            check("branch_cnt",     branch_cnt,            mon_e.bcnt);
            check("mispredict_cnt", mispredict_cnt,        mon_e.mcnt);
            check("pred_taken",     {31'd0, pred_taken},   {31'd0, mon_e.pred});
            if (mon_e.chk_u) begin
                check("unsigned flush",        {31'd0, u_flush},        {31'd0, mon_e.u_flush});
                check("unsigned actual_taken", {31'd0, u_actual_taken}, {31'd0, mon_e.u_taken});
                check("unsigned cmp_result",   {30'd0, u_cmp_result},   {30'd0, mon_e.u_cmp});
            end
        end
    end

    task automatic step(input logic v, input logic st, input logic [31:0] pc,
                        input logic [2:0] cond, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] tgt, input logic pt, input logic [31:0] ppc,
                        input exp_t e);
        @(negedge clk);
        res_valid = v; stall = st; res_pc = pc; res_cond = cond;
        rs_data = rs; rt_data = rt; res_target = tgt; res_pred_taken = pt;
        pred_pc = ppc;
        sb_q.push_back(e);
    endtask

    task automatic idle(input logic [31:0] ppc, input exp_t e);
        step(1'b0, 1'b0, 32'h0, 3'd7, 32'h0, 32'h0, 32'h0, 1'b0, ppc, e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    exp_t e;
    initial begin
        rst = 1'b1; pred_pc = '0; stall = 1'b0; res_valid = 1'b0; res_pc = '0;
        res_cond = '0; rs_data = '0; rt_data = '0; res_target = '0; res_pred_taken = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset flush",          {31'd0, flush},        32'd0);
        check("reset actual_taken",   {31'd0, actual_taken}, 32'd0);
        check("reset cmp_result",     {30'd0, cmp_result},   32'd0);
        check("reset redirect_pc",    redirect_pc,           32'd0);
        check("reset branch_cnt",     branch_cnt,            32'd0);
        check("reset mispredict_cnt", mispredict_cnt,        32'd0);
        check("reset pred pc0",       {31'd0, pred_taken},   32'd0);
        pred_pc = 32'h100; #1;
        check("reset pred pc100",     {31'd0, pred_taken},   32'd0);
        pred_pc = 32'hFFC; #1;
        check("reset pred pcffc",     {31'd0, pred_taken},   32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Signed boundary BLTZ; the unsigned instance sees 0x80000000 > 0
        e = mk(1'b1, 1'b1, 2'b10, 32'h200, 32'd1, 32'd1, 1'b1);
        e.chk_u = 1'b1; e.u_flush = 1'b0; e.u_taken = 1'b0; e.u_cmp = 2'b11;
        step(1'b1, 1'b0, 32'h40, 3'd2, 32'h8000_0000, 32'h0, 32'h200, 1'b0, 32'h40, e);
        idle(32'h100, mk(1'b0, 1'b0, 2'b00, 32'h200, 32'd1, 32'd1, 1'b0));

        // Saturation at 0x100: 1 -> 2 -> 3 -> 3 -> 3
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 32'h100, 3'd0, 32'd7, 32'd7, 32'h300, 1'b1, 32'h100,
                 mk(1'b0, 1'b1, 2'b01, 32'h300, 32'(2 + i), 32'd1, 1'b1));
        end
        // Not-taken BGTZ rs=0: 3 -> 2, prediction holds
        step(1'b1, 1'b0, 32'h100, 3'd3, 32'd0, 32'd0, 32'h300, 1'b0, 32'h100,
             mk(1'b0, 1'b0, 2'b01, 32'h104, 32'd6, 32'd1, 1'b1));
        // Not-taken BLTZ rs=5: 2 -> 1, prediction flips
        step(1'b1, 1'b0, 32'h100, 3'd2, 32'd5, 32'd0, 32'h300, 1'b0, 32'h100,
             mk(1'b0, 1'b0, 2'b11, 32'h104, 32'd7, 32'd1, 1'b0));

        // BNE equal operands predicted taken -> mispredict, then wrong-path drop
        step(1'b1, 1'b0, 32'h504, 3'd1, 32'd5, 32'd5, 32'h600, 1'b1, 32'h100,
             mk(1'b1, 1'b0, 2'b01, 32'h508, 32'd8, 32'd2, 1'b0));
        step(1'b1, 1'b0, 32'h100, 3'd0, 32'd1, 32'd1, 32'h300, 1'b0, 32'h100,
             mk(1'b0, 1'b0, 2'b00, 32'h508, 32'd8, 32'd2, 1'b0));

        // Never-taken cond at top of address space: redirect wraps to 0
        step(1'b1, 1'b0, 32'hFFFF_FFFC, 3'd6, 32'd0, 32'd0, 32'h900, 1'b1, 32'h100,
             mk(1'b1, 1'b0, 2'b01, 32'h0, 32'd9, 32'd3, 1'b0));
        idle(32'h100, mk(1'b0, 1'b0, 2'b00, 32'h0, 32'd9, 32'd3, 1'b0));

        // Collision: read at the updated index sees the old counter (1)
        step(1'b1, 1'b0, 32'h100, 3'd0, 32'd3, 32'd3, 32'h300, 1'b1, 32'h100,
             mk(1'b0, 1'b1, 2'b01, 32'h300, 32'd10, 32'd3, 1'b1));
        #1;
        check("collision old value", {31'd0, pred_taken}, 32'd0);

        // Stalled resolve: no output, no count, no table change
        step(1'b1, 1'b1, 32'h100, 3'd1, 32'd3, 32'd3, 32'h300, 1'b1, 32'h100,
             mk(1'b0, 1'b0, 2'b00, 32'h300, 32'd10, 32'd3, 1'b1));

        // BLEZ rs=1 predicted taken -> mispredict, then reset while flush is high
        step(1'b1, 1'b0, 32'h100, 3'd4, 32'd1, 32'd0, 32'h800, 1'b1, 32'h40,
             mk(1'b1, 1'b0, 2'b11, 32'h104, 32'd11, 32'd4, 1'b1));
        @(negedge clk);
        res_valid = 1'b0; stall = 1'b0; pred_pc = 32'h40;
        rst = 1'b1;
        #1;
        check("midreset flush",      {31'd0, flush},      32'd0);
        check("midreset branch_cnt", branch_cnt,          32'd0);
        check("midreset mis_cnt",    mispredict_cnt,      32'd0);
        check("midreset redirect",   redirect_pc,         32'd0);
        check("midreset pred pc40",  {31'd0, pred_taken}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // BGEZ rs=1 after reset: taken, counter 1 -> 2
        step(1'b1, 1'b0, 32'h40, 3'd5, 32'd1, 32'd0, 32'h700, 1'b1, 32'h40,
             mk(1'b0, 1'b1, 2'b11, 32'h700, 32'd1, 32'd0, 1'b1));
        idle(32'h40, mk(1'b0, 1'b0, 2'b00, 32'h700, 32'd1, 32'd0, 1'b1));

        repeat (3) @(negedge clk);
        check("scoreboard drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolve_bht.md
# branch_resolve_bht

Parametrised branch resolution unit with a built-in bimodal history table (BHT) of saturating counters. The IF stage reads a taken/not-taken prediction from it combinationally. The EX stage hands it resolved operands; it compares them (signed or unsigned, register-register or against zero) and updates the table. One cycle later it raises a registered flush/redirect on a misprediction. It also keeps saturating branch and mispredict statistics counters.

## Interface
- DATA_W, 32, operand width
- PC_W, 32, program counter width
- BHT_DEPTH, 64, number of table entries (power of two, ≥2); IDX_W = log2(BHT_DEPTH)
- CNT_W, 2, saturating counter width (≥1)
- INIT_CNT, 1, reset value of every counter (must be < 2^CNT_W)
- SIGNED_CMP, 1, 1 = two's-complement compare, 0 = unsigned
- STAT_W, 32, width of the statistics counters

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- pred_pc  in  PC_W  IF-stage fetch PC
- pred_taken  out  1  combinational prediction: MSB of counter at index pred_pc[IDX_W+1:2]
- stall  in  1  EX hold; a resolve is ignored while high
- res_valid  in  1  branch present in EX
- res_pc  in  PC_W  PC of the branch
- res_cond  in  3  0 BEQ, 1 BNE, 2 BLTZ, 3 BGTZ, 4 BLEZ, 5 BGEZ, 6/7 never-taken
- rs_data  in  DATA_W  first operand
- rt_data  in  DATA_W  second operand; ignored for conds 2–7
- res_target  in  PC_W  taken target
- res_pred_taken  in  1  prediction carried down the pipeline with this branch
- flush  out  1  registered misprediction pulse
- redirect_pc  out  PC_W  registered correct next PC, meaningful while flush=1
- actual_taken  out  1  registered resolved direction
- cmp_result  out  2  registered compare: 00 none, 01 equal, 10 less, 11 greater
- branch_cnt  out  STAT_W  accepted resolves
- mispredict_cnt  out  STAT_W  mispredictions

## Operation
- Accept: acc = res_valid & ~stall & ~flush. A resolve presented in the cycle flush is high is a wrong-path instruction. It is dropped: no table update, no output, no count.
- Compare operand: B = rt_data for conds 0/1, B = 0 for all other conds. Compare rs_data against B using SIGNED_CMP.
- Compare result: equal → 01, rs<B → 10, rs>B → 11.
- Taken for conds 0–5: EQ, NE, LT, GT, LE, GE against the compare result. Conds 6/7 are never taken.
- Misprediction: mis = taken ≠ res_pred_taken.
- Redirect: redirect_pc = res_target if taken, else res_pc + 4 (modulo 2^PC_W).
- Table update on acc, at index res_pc[IDX_W+1:2]:
  - taken: increment, saturating at 2^CNT_W−1.
  - not taken: decrement, saturating at 0.
- Read/update collision: a prediction read at the same index as an update in the same cycle returns the pre-update value. There is no bypass.
- Statistics:
  - branch_cnt increments on acc.
  - mispredict_cnt increments on acc & mis.
  - Both saturate at 2^STAT_W−1.
- Output registers:
  - On acc: flush←mis, actual_taken←taken, cmp_result←result, redirect_pc←redirect.
  - Otherwise: flush←0, cmp_result←00, actual_taken←0. redirect_pc holds.

## Timing
- Reset (asynchronous, immediate):
  - All counters = INIT_CNT.
  - flush=0, actual_taken=0, cmp_result=00, redirect_pc=0, branch_cnt=0, mispredict_cnt=0.
  - pred_taken therefore equals INIT_CNT MSB.
- Latency:
  - Prediction: 0 cycles, combinational.
  - Resolve inputs at edge N → outputs visible after edge N+1. The table update is visible to pred_taken after edge N+1.
- flush is a single-cycle pulse per mispredicted branch.
- Back-to-back mispredicts: the second is suppressed, because flush is high in its accept cycle.
- stall high: no update, outputs clear to idle after the next edge, counters hold.
- Reset asserted mid-operation: a pending flush is cancelled and the whole table is re-initialised. Operation resumes on the first edge after deassertion.

## Test plan
- Reset with defaults → pred_taken=0 for any PC, all outputs 0, branch_cnt=0.
- Signed compare at the boundary, with res_pred_taken=0:
  - BLTZ, rs=0x80000000 → taken, cmp_result=10, flush=1, redirect_pc=res_target.
  - Same case with SIGNED_CMP=0 → not taken, cmp_result=11, flush=0.
- Saturation at one PC (0x100):
  - Four taken resolves from INIT_CNT=1 → counter 3; pred_taken=1 from the cycle after the first update.
  - Then one not-taken → counter 2, pred_taken still 1.
- Mispredict then wrong-path drop:
  - BNE, rs=5, rt=5, res_pred_taken=1 → flush=1, redirect_pc=res_pc+4.
  - Next-cycle resolve → ignored; branch_cnt=1, mispredict_cnt=1.
  - With res_pc=0xFFFFFFFC → redirect_pc wraps to 0.
- Collision and stall:
  - Update and read at the same index in one cycle → read returns the old value.
  - res_valid with stall=1 → no flush, counters unchanged.
- Reset mid-flush: assert rst in the cycle after a mispredict is accepted → flush reads 0 immediately and the table returns to INIT_CNT.
